// File: rtl/irq_arbiter_if.sv
// CPU data-bus view of the interrupt arbiter register block.
// The master drives address/data/strobes, and the slave returns combinational load data.
interface irq_arbiter_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;

    modport master (
        output address,
        output write_data,
        output mem_read,
        output mem_write,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  mem_read,
        input  mem_write,
        output read_data
    );
endinterface

// File: rtl/irq_arbiter.sv
// Four-source, fixed-priority interrupt arbiter with memory-mapped IE/PEND/CAUSE/CNT.
// Sources are edge-detected into PEND, and one request at a time is presented to the CPU.
module irq_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
    input  logic             clk,
    input  logic             reset,
    irq_arbiter_if.slave     bus,
    input  logic [3:0]       irq_src,
    input  logic             supervisor,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [4:0]  ie;
    logic [3:0]  pend;
    logic [3:0]  src_q;
    logic        cause_valid;
    logic [1:0]  cause_id;
    logic [15:0] cnt;
    logic [1:0]  id, id_next;
    logic [1:0]  first_id;
    logic        take, done;

    logic [3:0]  ie_src;
    logic        gie;
    logic [3:0]  active;
    logic [3:0]  rise;
    logic [3:0]  clr_mask;
    logic        sel_ie, sel_pend, sel_cause, sel_cnt;
    logic        wr_ie, wr_pend, wr_cnt;
    logic        unused_wdata;

    assign ie_src = ie[3:0];
    assign gie    = ie[4];
    assign active = pend & ie_src;
    assign rise   = irq_src & ~src_q;

    assign sel_ie    = (bus.address == BASE_ADDR);
    assign sel_pend  = (bus.address == BASE_ADDR + 32'h4);
    assign sel_cause = (bus.address == BASE_ADDR + 32'h8);
    assign sel_cnt   = (bus.address == BASE_ADDR + 32'hC);

    assign wr_ie   = bus.mem_write & sel_ie;
    assign wr_pend = bus.mem_write & sel_pend;
    assign wr_cnt  = bus.mem_write & sel_cnt;

    assign clr_mask     = wr_pend ? bus.write_data[3:0] : 4'h0;
    assign unused_wdata = &{1'b0, bus.write_data[31:5]};

    assign irq = (state == S_ASSERT);

    // Bit 0 wins the arbitration.
    always_comb begin
        first_id = 2'd3;
        if (active[0])      first_id = 2'd0;
        else if (active[1]) first_id = 2'd1;
        else if (active[2]) first_id = 2'd2;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        id_next    = id;
        take       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (gie && (active != 4'h0) && !supervisor) begin
                    state_next = S_ASSERT;
                    id_next    = first_id;
                end
            end
            S_ASSERT: begin
                // A withdrawn request is cancelled before the CPU can take it.
                if (!pend[id] || !ie_src[id] || !gie) begin
                    state_next = S_IDLE;
                end else if (supervisor) begin
                    state_next = S_SERVICE;
                    take       = 1'b1;
                end
            end
            S_SERVICE: begin
                if (!supervisor) begin
                    state_next = S_IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments, and reset is synchronous, so it is sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            id          <= 2'd0;
            src_q       <= 4'h0;
            ie          <= 5'h0;
            pend        <= 4'h0;
            cause_valid <= 1'b0;
            cause_id    <= 2'd0;
            cnt         <= 16'h0;
        end else begin
            state <= state_next;
            id    <= id_next;
            src_q <= irq_src;
            if (wr_ie) ie <= bus.write_data[4:0];
            // A new edge beats a simultaneous write-one-to-clear.
            pend <= (pend & ~clr_mask) | rise;
            if (take) begin
                cause_valid <= 1'b1;
                cause_id    <= id;
            end else if (done) begin
                cause_valid <= 1'b0;
            end
            if (wr_cnt)
                cnt <= 16'h0;
            else if (take && (cnt != 16'hFFFF))
                cnt <= cnt + 16'd1;
        end
    end

    always_comb begin
        bus.read_data = 32'h0;
        if (bus.mem_read) begin
            if (sel_ie)         bus.read_data = {27'h0, ie};
            else if (sel_pend)  bus.read_data = {28'h0, pend};
            else if (sel_cause) bus.read_data = {27'h0, cause_valid, 2'b00, cause_id};
            else if (sel_cnt)   bus.read_data = {16'h0, cnt};
        end
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter: BASE_ADDR, 32'h40000030, word address of the first register (IE); PEND, CAUSE and CNT follow at +4, +8 and +C.
REQ-002 Ports:
  clk  in  1  system clock.
  reset  in  1  synchronous, active-high; one clock; all state is cleared on the clk edge where reset=1.
  irq_src  in  4  level interrupt sources; bit0 highest priority.
  supervisor  in  1  CPU is in kernel mode (PC[31]).
  address  in  32  CPU data bus address.
  write_data  in  32  CPU store data.
  mem_read  in  1  load strobe.
  mem_write  in  1  store strobe.
  read_data  out  32  load data.
  irq  out  1  interrupt request to the CPU controller.

Function
REQ-003 Register map:
  IE: [3:0] source enables, [4] global enable GIE; read/write.
  PEND: [3:0] pending; read; writing 1 to a bit clears it.
  CAUSE: [4] valid, [1:0] serviced id; read-only.
  CNT: [15:0] serviced-interrupt count; read; any write clears it.
REQ-004 read_data is combinational: when mem_read=1 and the address matches a register, it carries that register zero-extended; otherwise 32'h0.
REQ-005 Writes take effect on the clk edge where mem_write=1 and the address matches; unmapped writes are ignored.
REQ-006 Each irq_src bit is registered (src_q); a rising edge (irq_src & ~src_q) sets the PEND bit on the next edge.
REQ-007 When a PEND bit is set and W1C-cleared in the same cycle, set wins.
REQ-008 FSM states and transitions:
  IDLE -> ASSERT when GIE=1, (PEND & IE[3:0]) != 0 and supervisor=0; lowest set index is latched into id.
  ASSERT -> SERVICE when supervisor=1.
  ASSERT -> IDLE (cancel) when PEND[id]=0, IE[id]=0 or GIE=0; CNT is unchanged on a cancel.
  SERVICE -> IDLE when supervisor=0.
REQ-009 irq=1 exactly while the state is ASSERT (registered; it rises one clock after the IDLE condition holds).
REQ-010 On ASSERT->SERVICE, CAUSE takes valid=1 with the latched id, and CNT increments, saturating at 16'hFFFF.
REQ-011 CAUSE.valid clears on SERVICE->IDLE; the id field holds its last value.
REQ-012 PEND is not auto-cleared; the handler must W1C it, otherwise the same source re-arbitrates after return.
REQ-013 No nesting: a higher-priority arrival during SERVICE stays pending until IDLE.
REQ-014 A CNT write coincident with an increment clears CNT; the clear wins.
REQ-015 With supervisor=1 in IDLE, irq stays 0 regardless of pending sources.

Reset
REQ-016 On reset: state=IDLE, irq=0, and IE, PEND, CAUSE, CNT, id and src_q all =0.
REQ-017 A source held high across reset sets its PEND bit on the first edge after reset deasserts, because src_q resets to 0.
REQ-018 Reset asserted in ASSERT or SERVICE returns to IDLE with irq=0 on that edge.

Verification
REQ-019 Write IE=5'h1F; pulse irq_src=4'b0100 with supervisor=0 -> PEND=4'b0100 and irq=1; raise supervisor -> irq=0, CAUSE=5'h12, CNT=1.
REQ-020 Pulse irq_src bits 3 and 1 in the same cycle with IE=5'h1F -> id=1; W1C PEND=4'b0010 and drop supervisor -> second service with CAUSE=5'h13, CNT=2.
REQ-021 With irq=1, write IE=5'h00 -> irq=0 next cycle, state=IDLE, CNT unchanged, PEND still set.
REQ-022 Hold supervisor=1; pulse irq_src[0] with IE=5'h1F -> irq stays 0; drop supervisor -> irq=1 one cycle later.
REQ-023 W1C PEND[2] in the same cycle as a rising edge on irq_src[2] -> PEND[2]=1; preload CNT to FFFF via 65535 services or force -> a further service leaves CNT=FFFF.
REQ-024 Assert reset during SERVICE with CAUSE=5'h10 -> all registers read 0 next cycle and irq=0.
